// File: rtl/pipe_reg_elastic.sv
// Elastic pipeline register: DEPTH stages with valid/ready handshake, bubble collapse,
// optional per-stage skid entry for a registered upstream ready, plus stall and flush.
module pipe_reg_elastic #(
  parameter int DATA_W = 133,
  parameter int DEPTH  = 1,
  parameter int SKID   = 0
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              InValid,
  output logic              InReady,
  input  logic [DATA_W-1:0] InData,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] OutData,
  input  logic              Stall,
  input  logic              Flush,
  output logic [3:0]        Count
);

  logic [DEPTH-1:0]  r_mv;
  logic [DATA_W-1:0] r_md [DEPTH];
  logic              w_block;
  logic              w_in_fire;
  logic [DEPTH-1:0]  w_ld;
  logic [DATA_W-1:0] w_src [DEPTH];

  assign w_block   = Rst | Flush | Stall;
  assign OutValid  = r_mv[DEPTH-1] & ~w_block;
  assign OutData   = r_md[DEPTH-1];
  assign w_in_fire = InValid & InReady;

  // Stage 0 loads from the input port, every later stage from its predecessor's main entry
  always_comb begin
    w_src[0] = InData;
    for (int i = 1; i < DEPTH; i++) w_src[i] = r_md[i-1];
  end

  if (SKID == 0) begin : g_comb
    logic [DEPTH-1:0] w_adv;

    // A stage advances when some later stage is empty (bubble collapses) or the tail is popped
    always_comb begin
      logic tail_full;
      tail_full = 1'b1;
      w_adv     = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
        w_adv[i]  = r_mv[i] & ~w_block & (~tail_full | OutReady);
        tail_full = tail_full & r_mv[i];
      end
    end

    always_comb begin
      w_ld[0] = w_in_fire;
      for (int i = 1; i < DEPTH; i++) w_ld[i] = w_adv[i-1];
    end

    assign InReady = ~w_block & (~r_mv[0] | w_adv[0]);

    always_ff @(posedge Clk) begin
      if (Rst) begin
        r_mv <= '0;
        for (int i = 0; i < DEPTH; i++) r_md[i] <= '0;
      end else if (Flush) begin
        r_mv <= '0;
      end else if (!Stall) begin
        for (int i = 0; i < DEPTH; i++) begin
          r_mv[i] <= w_ld[i] | (r_mv[i] & ~w_adv[i]);
          if (w_ld[i]) r_md[i] <= w_src[i];
        end
      end
    end

    always_comb begin
      Count = '0;
      for (int i = 0; i < DEPTH; i++) Count = Count + 4'(r_mv[i]);
    end
  end else begin : g_skid
    logic [DEPTH-1:0]  r_sv;
    logic [DATA_W-1:0] r_sd [DEPTH];
    logic              r_in_rdy;
    logic [DEPTH-1:0]  w_succ_rdy;
    logic [DEPTH-1:0]  w_ofire;
    logic [DEPTH-1:0]  w_mv_n;
    logic [DEPTH-1:0]  w_sv_n;
    logic [DATA_W-1:0] w_md_n [DEPTH];
    logic [DATA_W-1:0] w_sd_n [DEPTH];

    // A successor can always take one entry while its skid slot is free
    always_comb begin
      w_succ_rdy[DEPTH-1] = OutReady;
      for (int i = 0; i < DEPTH - 1; i++) w_succ_rdy[i] = ~r_sv[i+1];
    end

    assign w_ofire = r_mv & w_succ_rdy & {DEPTH{~w_block}};

    always_comb begin
      w_ld[0] = w_in_fire;
      for (int i = 1; i < DEPTH; i++) w_ld[i] = w_ofire[i-1];
    end

    assign InReady = r_in_rdy & ~w_block;

    // Main entry is always the older one; a held skid entry refills main before new input
    always_comb begin
      w_mv_n = r_mv;
      w_sv_n = r_sv;
      for (int i = 0; i < DEPTH; i++) begin
        w_md_n[i] = r_md[i];
        w_sd_n[i] = r_sd[i];
        if (r_sv[i]) begin
          if (w_ofire[i]) begin
            w_md_n[i] = r_sd[i];
            w_sv_n[i] = 1'b0;
          end
        end else if (w_ld[i]) begin
          if (~r_mv[i] | w_ofire[i]) begin
            w_md_n[i] = w_src[i];
            w_mv_n[i] = 1'b1;
          end else begin
            w_sd_n[i] = w_src[i];
            w_sv_n[i] = 1'b1;
          end
        end else if (w_ofire[i]) begin
          w_mv_n[i] = 1'b0;
        end
      end
    end

    always_ff @(posedge Clk) begin
      if (Rst) begin
        r_mv     <= '0;
        r_sv     <= '0;
        r_in_rdy <= 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
          r_md[i] <= '0;
          r_sd[i] <= '0;
        end
      end else if (Flush) begin
        r_mv     <= '0;
        r_sv     <= '0;
        r_in_rdy <= 1'b1;
      end else if (!Stall) begin
        r_mv     <= w_mv_n;
        r_sv     <= w_sv_n;
        r_in_rdy <= ~w_sv_n[0];
        for (int i = 0; i < DEPTH; i++) begin
          r_md[i] <= w_md_n[i];
          r_sd[i] <= w_sd_n[i];
        end
      end
    end

    always_comb begin
      Count = '0;
      for (int i = 0; i < DEPTH; i++) Count = Count + 4'(r_mv[i]) + 4'(r_sv[i]);
    end
  end

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// Directed bench for pipe_reg_elastic: four instances covering DEPTH/SKID combinations,
// each driven through a linear sequence with hand-computed expectations.
module tb_pipe_reg_elastic;
  localparam int W = 133;

  logic clk;
  int total = 0;
  int bad = 0;

  logic a_rst, a_iv, a_or, a_st, a_fl, a_ir, a_ov;
  logic b_rst, b_iv, b_or, b_st, b_fl, b_ir, b_ov;
  logic c_rst, c_iv, c_or, c_st, c_fl, c_ir, c_ov;
  logic d_rst, d_iv, d_or, d_st, d_fl, d_ir, d_ov;
  logic [W-1:0] a_id, a_od, b_id, b_od, c_id, c_od, d_id, d_od;
  logic [3:0] a_cnt, b_cnt, c_cnt, d_cnt;

  pipe_reg_elastic #(.DATA_W(W), .DEPTH(1), .SKID(0)) u_a (
    .Clk(clk), .Rst(a_rst), .InValid(a_iv), .InReady(a_ir), .InData(a_id),
    .OutValid(a_ov), .OutReady(a_or), .OutData(a_od), .Stall(a_st), .Flush(a_fl), .Count(a_cnt));
  pipe_reg_elastic #(.DATA_W(W), .DEPTH(3), .SKID(0)) u_b (
    .Clk(clk), .Rst(b_rst), .InValid(b_iv), .InReady(b_ir), .InData(b_id),
    .OutValid(b_ov), .OutReady(b_or), .OutData(b_od), .Stall(b_st), .Flush(b_fl), .Count(b_cnt));
  pipe_reg_elastic #(.DATA_W(W), .DEPTH(2), .SKID(1)) u_c (
    .Clk(clk), .Rst(c_rst), .InValid(c_iv), .InReady(c_ir), .InData(c_id),
    .OutValid(c_ov), .OutReady(c_or), .OutData(c_od), .Stall(c_st), .Flush(c_fl), .Count(c_cnt));
  pipe_reg_elastic #(.DATA_W(W), .DEPTH(4), .SKID(0)) u_d (
    .Clk(clk), .Rst(d_rst), .InValid(d_iv), .InReady(d_ir), .InData(d_id),
    .OutValid(d_ov), .OutReady(d_or), .OutData(d_od), .Stall(d_st), .Flush(d_fl), .Count(d_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    int sent, rcv, cyc;
    {a_rst, b_rst, c_rst, d_rst} = 4'hF;
    {a_iv, b_iv, c_iv, d_iv} = '0;
    {a_or, b_or, c_or, d_or} = '0;
    {a_st, b_st, c_st, d_st} = '0;
    {a_fl, b_fl, c_fl, d_fl} = '0;
    a_id = '0; b_id = '0; c_id = '0; d_id = '0;

    // reset state
    step();
    a_iv = 1'b1; c_iv = 1'b1;
    #1;
    chk("rst_a_inready", a_ir, 0);
    chk("rst_c_inready", c_ir, 0);
    chk("rst_a_outvalid", a_ov, 0);
    chk("rst_a_count", a_cnt, 0);
    chk("rst_b_count", b_cnt, 0);
    chk("rst_c_count", c_cnt, 0);
    chk("rst_d_count", d_cnt, 0);
    chk("rst_a_data", a_od, 0);
    chk("rst_c_data", c_od, 0);
    chk("rst_d_data", d_od, 0);
    {a_rst, b_rst, c_rst, d_rst} = '0;
    c_iv = 1'b0;

    // A: DEPTH=1 SKID=0, streaming with OutReady=1
    a_id = W'(1); a_or = 1'b1;
    #1;
    chk("a_first_ready", a_ir, 1);
    step(); a_id = W'(2); #1;
    chk("a_ov1", a_ov, 1);
    chk("a_od1", a_od, 1);
    chk("a_cnt1", a_cnt, 1);
    chk("a_ir1", a_ir, 1);
    step(); a_id = W'(3); #1;
    chk("a_od2", a_od, 2);
    chk("a_cnt2", a_cnt, 1);
    step(); a_iv = 1'b0; #1;
    chk("a_od3", a_od, 3);
    chk("a_cnt3", a_cnt, 1);
    step(); #1;
    chk("a_ov_empty", a_ov, 0);
    chk("a_cnt_empty", a_cnt, 0);

    // B: DEPTH=3 SKID=0, fill under backpressure then drain
    b_or = 1'b0; b_iv = 1'b1; b_id = W'(8'h10);
    #1; chk("b_ir0", b_ir, 1);
    step(); b_id = W'(8'h11); #1;
    chk("b_ir1", b_ir, 1); chk("b_cnt1", b_cnt, 1);
    step(); b_id = W'(8'h12); #1;
    chk("b_ir2", b_ir, 1); chk("b_cnt2", b_cnt, 2);
    step(); b_id = W'(8'h13); #1;
    chk("b_ir_full", b_ir, 0); chk("b_cnt3", b_cnt, 3);
    chk("b_ov_full", b_ov, 1); chk("b_od_head", b_od, 8'h10);
    step(); b_id = W'(8'h14); #1;
    chk("b_ir_full2", b_ir, 0); chk("b_cnt_hold", b_cnt, 3);
    b_iv = 1'b0; b_or = 1'b1; #1;
    chk("b_pop0", b_od, 8'h10); chk("b_pc0", b_cnt, 3);
    step(); #1;
    chk("b_pop1", b_od, 8'h11); chk("b_pc1", b_cnt, 2);
    step(); #1;
    chk("b_pop2", b_od, 8'h12); chk("b_pc2", b_cnt, 1);
    step(); #1;
    chk("b_drained_cnt", b_cnt, 0); chk("b_drained_ov", b_ov, 0);

    // C: DEPTH=2 SKID=1, OutReady toggling, 20 words in order
    sent = 0; rcv = 0; cyc = 0;
    while (rcv < 20 && cyc < 200) begin
      c_iv = (sent < 20);
      c_id = W'(sent);
      c_or = (cyc % 2 == 0);
      #1;
      if (c_ov && c_or) begin
        chk("c_order", c_od, rcv);
        rcv++;
      end
      chk("c_count_max", (c_cnt <= 4), 1);
      if (c_iv && c_ir) sent++;
      step();
      cyc++;
    end
    chk("c_all_out", rcv, 20);
    chk("c_all_in", sent, 20);

    // D: stall with two entries in flight (same DEPTH=2 SKID=1 instance)
    c_or = 1'b0; c_iv = 1'b1; c_id = W'(8'hA1);
    #1; chk("d_ir0", c_ir, 1);
    step(); c_id = W'(8'hA2); #1;
    step(); c_iv = 1'b0; #1;
    chk("d_cnt2", c_cnt, 2); chk("d_ov", c_ov, 1); chk("d_od", c_od, 8'hA1);
    chk("d_ir_or0", c_ir, 1);
    c_or = 1'b1; #1;
    chk("d_ir_or1", c_ir, 1);
    c_st = 1'b1; c_iv = 1'b1; c_id = W'(8'hA3);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("d_stall_ir", c_ir, 0); chk("d_stall_ov", c_ov, 0);
      chk("d_stall_cnt", c_cnt, 2); chk("d_stall_od", c_od, 8'hA1);
      step();
    end
    c_st = 1'b0; c_iv = 1'b0; #1;
    chk("d_rel_ov", c_ov, 1); chk("d_rel_od0", c_od, 8'hA1);
    step(); #1;
    chk("d_rel_od1", c_od, 8'hA2); chk("d_rel_cnt1", c_cnt, 1);
    step(); #1;
    chk("d_rel_cnt0", c_cnt, 0);

    // D2: fill DEPTH=2 SKID=1 to 4 entries, ready drops, drain in order
    c_or = 1'b0; c_iv = 1'b1;
    for (int k = 0; k < 4; k++) begin
      c_id = W'(8'hB1 + k);
      #1; chk("f_ir_fill", c_ir, 1);
      step();
    end
    c_iv = 1'b0; #1;
    chk("f_cnt4", c_cnt, 4); chk("f_ir_full", c_ir, 0);
    c_or = 1'b1; #1;
    chk("f_ir_full_or1", c_ir, 0);
    for (int k = 0; k < 4; k++) begin
      #1; chk("f_drain", c_od, 8'hB1 + k); chk("f_drain_ov", c_ov, 1);
      step();
    end
    #1; chk("f_empty", c_cnt, 0);

    // E: DEPTH=4 flush while full with a concurrent input, then latency
    d_or = 1'b0; d_iv = 1'b1;
    for (int k = 0; k < 4; k++) begin
      d_id = W'(8'h41 + k);
      #1; chk("e_ir_fill", d_ir, 1);
      step();
    end
    d_id = W'(8'h55); d_fl = 1'b1; #1;
    chk("e_cnt4", d_cnt, 4); chk("e_fl_ir", d_ir, 0); chk("e_fl_ov", d_ov, 0);
    step(); d_fl = 1'b0; d_iv = 1'b0; d_or = 1'b1; #1;
    chk("e_cnt0", d_cnt, 0); chk("e_ov0", d_ov, 0);
    for (int k = 0; k < 5; k++) begin
      step(); #1; chk("e_no_ghost", d_ov, 0);
    end
    d_iv = 1'b1; d_id = W'(8'h66); #1;
    chk("e_lat_ir", d_ir, 1);
    step(); d_iv = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1; chk("e_lat_early", d_ov, 0);
      step();
    end
    #1; chk("e_lat_ov", d_ov, 1); chk("e_lat_od", d_od, 8'h66);

    // F: reset beats flush and stall with two entries held
    b_or = 1'b0; b_iv = 1'b1; b_id = W'(8'h21);
    step(); b_id = W'(8'h22);
    step(); b_iv = 1'b0; #1;
    chk("r_cnt2", b_cnt, 2);
    b_rst = 1'b1; b_fl = 1'b1; b_st = 1'b1; b_iv = 1'b1; b_id = W'(8'h99); #1;
    chk("r_ir", b_ir, 0); chk("r_ov", b_ov, 0);
    step(); b_rst = 1'b0; b_fl = 1'b0; b_st = 1'b0; b_iv = 1'b0; #1;
    chk("r_cnt0", b_cnt, 0); chk("r_od0", b_od, 0); chk("r_ov0", b_ov, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_reg_elastic.md
PIPE_REG_ELASTIC -- requirements
Module: pipe_reg_elastic

Interface
REQ-001 Parameter DATA_W, default 133, SHALL set the payload width (four 32-bit fields plus a 5-bit register index).
REQ-002 Parameter DEPTH, default 1, legal 1..4, SHALL set the number of register stages in series.
REQ-003 Parameter SKID, default 0, legal 0/1, SHALL select a combinational ready chain (0) or a per-stage skid buffer with registered ready (1).
REQ-004 Clk  input  1  sole clock; all state SHALL update on its rising edge only.
REQ-005 Rst  input  1  reset, synchronous and active-high.
REQ-006 InValid  input  1  upstream payload valid.
REQ-007 InReady  output  1  block accepts payload this cycle.
REQ-008 InData  input  DATA_W  upstream payload.
REQ-009 OutValid  output  1  payload at OutData is valid.
REQ-010 OutReady  input  1  downstream accepts payload this cycle.
REQ-011 OutData  output  DATA_W  payload of the oldest valid entry.
REQ-012 Stall  input  1  freeze all stages.
REQ-013 Flush  input  1  discard all in-flight entries.
REQ-014 Count  output  4  number of valid entries held, 0..DEPTH*(1+SKID).

Function
REQ-015 Input transfer SHALL occur when InValid and InReady are both 1 on a rising edge; output transfer when OutValid and OutReady are both 1.
REQ-016 Each stage SHALL hold one main entry (valid bit + DATA_W data); with SKID=1 each stage SHALL also hold one skid entry.
REQ-017 SKID=0: a stage SHALL advance when its successor is empty or advancing; InReady SHALL be combinationally !valid[0] or stage-0 advancing, derived from OutReady.
REQ-018 SKID=1: InReady SHALL be driven by a flop equal to "stage-0 skid entry empty"; an entry arriving while the main entry cannot advance SHALL go to the skid entry; the skid entry SHALL drain into the main entry before any new input.
REQ-019 Latency with no backpressure SHALL be exactly DEPTH cycles from input transfer to OutValid=1 with that payload.
REQ-020 Sustained throughput SHALL be one transfer per cycle when InValid=1 and OutReady=1 permanently, for both SKID values.
REQ-021 Empty stages SHALL be collapsed: a valid entry SHALL advance into an empty successor every non-stalled cycle regardless of OutReady.
REQ-022 Ordering SHALL be strict FIFO; no entry SHALL be duplicated or dropped except by Flush or Rst.
REQ-023 Data of an empty slot SHALL hold its last value; only valid bits gate visibility.
REQ-024 Stall=1: no valid bit or data register SHALL change; InReady=0 and OutValid=0 combinationally during that cycle; no transfer on either side.
REQ-025 Flush=1: all valid bits SHALL be 0 after the edge, Count=0; InReady=0 that cycle so no input is accepted; OutValid=0 that cycle.
REQ-026 Priority SHALL be Rst > Flush > Stall > normal operation.
REQ-027 Count SHALL equal the sum of valid bits each cycle; simultaneous input and output transfer SHALL leave Count unchanged.
REQ-028 When full (Count = DEPTH*(1+SKID)) and OutReady=0, InReady SHALL be 0.
REQ-029 With SKID=1, InReady SHALL never depend combinationally on OutReady, Stall excepted.

Reset
REQ-030 Rst=1 at an edge SHALL clear all valid bits, all data registers to 0, the SKID=1 ready flop to 1, and Count to 0.
REQ-031 During Rst=1, InReady SHALL be 0 and OutValid SHALL be 0; first input transfer SHALL be possible the cycle after Rst falls.
REQ-032 Rst asserted mid-stream SHALL discard all entries; no pre-reset payload SHALL appear at OutData as valid afterwards.

Verification
REQ-033 DEPTH=1, SKID=0, OutReady=1, push 0x..01,0x..02,0x..03 on consecutive cycles -> OutData 01,02,03 on cycles 1,2,3 after each push, Count stays 1.
REQ-034 DEPTH=3, SKID=0, OutReady=0, push 5 entries -> exactly 3 accepted, InReady=0 from 4th, Count=3; then OutReady=1 -> 3 pops in order, Count 3->0.
REQ-035 DEPTH=2, SKID=1, OutReady toggled 1/0 each cycle, InValid=1 with incrementing data 0..19 -> output sequence 0..19 with no gap or repeat, Count never exceeds 4.
REQ-036 DEPTH=2, 2 entries in flight, Stall=1 for 3 cycles -> Count, OutData unchanged, InReady=OutValid=0; release -> order preserved.
REQ-037 DEPTH=4, Count=4, Flush=1 with InValid=1 -> next cycle Count=0, OutValid=0, flushed input absent from output.
REQ-038 Rst=1 with Flush=1 and Stall=1 while Count=2 -> next cycle Count=0, OutData=0, OutValid=0.
